alu_bool_issue: RTL and testbench

ALU_BOOL_ISSUE -- requirements
Module: alu_bool_issue

---
 rtl/alu_bool_issue_pkg.sv | 34 +++
 rtl/alu_bool_issue_decode.sv | 46 ++++
 rtl/alu_bool_issue.sv | 119 +++++++++++
 tb/tb_alu_bool_issue.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bool_issue_pkg.sv
// Shared opcode, ALUOp and buffer-state definitions for the boolean issue stage.
package alu_bool_issue_pkg;

    localparam logic [5:0] OP_AND   = 6'h28;
    localparam logic [5:0] OP_OR    = 6'h29;
    localparam logic [5:0] OP_XOR   = 6'h2A;
    localparam logic [5:0] OP_XNOR  = 6'h2B;
    localparam logic [5:0] OP_ANDC  = 6'h38;
    localparam logic [5:0] OP_ORC   = 6'h39;
    localparam logic [5:0] OP_XORC  = 6'h3A;
    localparam logic [5:0] OP_XNORC = 6'h3B;
    localparam logic [5:0] OP_PASSA = 6'h1F;

    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1110;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_XNOR = 4'b1001;
    localparam logic [3:0] ALU_A    = 4'b1010;
    localparam logic [3:0] ALU_NONE = 4'b0000;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_e;

    typedef struct packed {
        logic [3:0]  aluop;
        logic        illegal;
        logic [31:0] a;
        logic [31:0] b;
    } slot_t;

endpackage

// File: rtl/alu_bool_issue_decode.sv
// Combinational Beta opcode decode for the boolean unit.
module alu_bool_decode
    import alu_bool_issue_pkg::*;
(
    input  logic [5:0] opcode_i,
    output logic [3:0] aluop_o,
    output logic       illegal_o,
    output logic       use_lit_o,
    output logic       zero_b_o
);

    always_comb begin
        aluop_o   = ALU_NONE;
        illegal_o = 1'b0;
        use_lit_o = 1'b0;
        zero_b_o  = 1'b0;
        unique case (opcode_i)
            OP_AND:   aluop_o = ALU_AND;
            OP_OR:    aluop_o = ALU_OR;
            OP_XOR:   aluop_o = ALU_XOR;
            OP_XNOR:  aluop_o = ALU_XNOR;
            OP_ANDC: begin
                aluop_o   = ALU_AND;
                use_lit_o = 1'b1;
            end
            OP_ORC: begin
                aluop_o   = ALU_OR;
                use_lit_o = 1'b1;
            end
            OP_XORC: begin
                aluop_o   = ALU_XOR;
                use_lit_o = 1'b1;
            end
            OP_XNORC: begin
                aluop_o   = ALU_XNOR;
                use_lit_o = 1'b1;
            end
            OP_PASSA: begin
                aluop_o  = ALU_A;
                zero_b_o = 1'b1;
            end
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_bool_issue.sv
// Boolean-op issue stage: decode, operand select, and a two-entry skid buffer.
module alu_bool_issue
    import alu_bool_issue_pkg::*;
#(
    parameter int LIT_W = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_opcode,
    input  logic [31:0]      in_ra_data,
    input  logic [31:0]      in_rb_data,
    input  logic [LIT_W-1:0] in_lit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_aluop,
    output logic [31:0]      out_a,
    output logic [31:0]      out_b,
    output logic             out_illegal,
    output logic [CNT_W-1:0] op_count
);

    state_e           state_q, state_d;
    slot_t            main_q, main_d;
    slot_t            skid_q, skid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]  dec_aluop;
    logic        dec_illegal;
    logic        dec_use_lit;
    logic        dec_zero_b;
    logic [31:0] lit_ext;
    slot_t       new_slot;
    logic        in_xfer;
    logic        out_xfer;

    alu_bool_decode u_decode (
        .opcode_i  (in_opcode),
        .aluop_o   (dec_aluop),
        .illegal_o (dec_illegal),
        .use_lit_o (dec_use_lit),
        .zero_b_o  (dec_zero_b)
    );

    assign lit_ext = 32'($signed(in_lit));

    always_comb begin
        new_slot.aluop   = dec_aluop;
        new_slot.illegal = dec_illegal;
        new_slot.a       = in_ra_data;
        new_slot.b       = in_rb_data;
        if (dec_zero_b) begin
            new_slot.b = 32'd0;
        end else if (dec_use_lit) begin
            new_slot.b = lit_ext;
        end
    end

    // Ready is a pure function of state so it never chains through out_ready.
    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        cnt_d   = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = new_slot;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = new_slot;
                end else if (in_xfer) begin
                    skid_d  = new_slot;
                    state_d = ST_TWO;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_aluop   = main_q.aluop;
    assign out_illegal = main_q.illegal;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu_bool_issue.sv
// Directed and streaming checks for the boolean issue stage.
module tb_alu_bool_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [5:0]  in_opcode;
    logic [31:0] in_ra_data;
    logic [31:0] in_rb_data;
    logic [15:0] in_lit;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [3:0]  out_aluop;
    logic [31:0] out_a, out_b;
    logic [15:0] op_count;

    logic        in_ready4, out_valid4, out_illegal4;
    logic [3:0]  out_aluop4;
    logic [31:0] out_a4, out_b4;
    logic [3:0]  op_count4;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [15:0] lit;
        logic [3:0]  aluop;
        logic        ill;
        logic [31:0] b;
    } vec_t;

    vec_t vecs[12];
    logic [68:0] sbq[$];

    alu_bool_issue #(.LIT_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_ra_data(in_ra_data),
        .in_rb_data(in_rb_data), .in_lit(in_lit),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluop(out_aluop), .out_a(out_a), .out_b(out_b),
        .out_illegal(out_illegal), .op_count(op_count)
    );

    alu_bool_issue #(.LIT_W(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_opcode(in_opcode), .in_ra_data(in_ra_data),
        .in_rb_data(in_rb_data), .in_lit(in_lit),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_aluop(out_aluop4), .out_a(out_a4), .out_b(out_b4),
        .out_illegal(out_illegal4), .op_count(op_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act,
                       input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] model(input logic [5:0] op,
                                          input logic [31:0] ra,
                                          input logic [31:0] rb,
                                          input logic [15:0] lit);
        logic [3:0]  f;
        logic        il;
        logic [31:0] b;
        il = 1'b0;
        b  = rb;
        case (op)
            6'h28, 6'h38: f = 4'b1000;
            6'h29, 6'h39: f = 4'b1110;
            6'h2A, 6'h3A: f = 4'b0110;
            6'h2B, 6'h3B: f = 4'b1001;
            6'h1F:        f = 4'b1010;
            default: begin
                f  = 4'b0000;
                il = 1'b1;
            end
        endcase
        if (!il && op[5:4] == 2'b11) b = {{16{lit[15]}}, lit};
        if (op == 6'h1F) b = 32'd0;
        return {f, il, ra, b};
    endfunction

    function automatic logic [68:0] vexp(input vec_t v);
        return {v.aluop, v.ill, v.ra, v.b};
    endfunction

    function automatic logic [68:0] outs();
        return {out_aluop, out_illegal, out_a, out_b};
    endfunction

    task automatic drive(input vec_t v);
        in_valid   = 1'b1;
        in_opcode  = v.op;
        in_ra_data = v.ra;
        in_rb_data = v.rb;
        in_lit     = v.lit;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic stream(input int n);
        logic [5:0] ops[12];
        int sent = 0;
        int got = 0;
        int stalls = 0;
        int cyc = 0;
        ops = '{6'h28, 6'h29, 6'h2A, 6'h2B, 6'h38, 6'h39,
                6'h3A, 6'h3B, 6'h1F, 6'h20, 6'h00, 6'h3F};
        sbq.delete();
        while ((sent < n || sbq.size() > 0) && cyc < n + 20) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (sent < n) begin
                in_valid   = 1'b1;
                in_opcode  = ($urandom_range(0, 3) == 0) ? 6'($urandom)
                                                         : ops[$urandom_range(0, 11)];
                in_ra_data = $urandom;
                in_rb_data = $urandom;
                in_lit     = 16'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("stream_spurious", 80'(outs()), 80'(0));
                end else begin
                    chk("stream_data", 80'(outs()), 80'(sbq.pop_front()));
                    got++;
                end
            end
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) begin
                sbq.push_back(model(in_opcode, in_ra_data, in_rb_data, in_lit));
                sent++;
            end
        end
        in_valid = 1'b0;
        chk("stream_outputs", 80'(got), 80'(n));
        chk("stream_stalls", 80'(stalls), 80'(0));
        chk("stream_cycles", 80'(cyc), 80'(n + 1));
        @(negedge clk);
    endtask

    initial begin
        int acc;
        vecs[0]  = '{6'h28, 32'hF0F01234, 32'h0F0FFFFF, 16'h8001, 4'b1000, 1'b0, 32'h0F0FFFFF};
        vecs[1]  = '{6'h38, 32'hFFFF0000, 32'h12345678, 16'h8001, 4'b1000, 1'b0, 32'hFFFF8001};
        vecs[2]  = '{6'h29, 32'h00000001, 32'h80000000, 16'h1234, 4'b1110, 1'b0, 32'h80000000};
        vecs[3]  = '{6'h39, 32'hA5A5A5A5, 32'h00000000, 16'h7FFF, 4'b1110, 1'b0, 32'h00007FFF};
        vecs[4]  = '{6'h2A, 32'h11111111, 32'hDEADBEEF, 16'hFFFF, 4'b0110, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{6'h3A, 32'h22222222, 32'h00000000, 16'hFFFF, 4'b0110, 1'b0, 32'hFFFFFFFF};
        vecs[6]  = '{6'h2B, 32'h33333333, 32'hCAFEF00D, 16'h0000, 4'b1001, 1'b0, 32'hCAFEF00D};
        vecs[7]  = '{6'h3B, 32'h44444444, 32'hFFFFFFFF, 16'h0000, 4'b1001, 1'b0, 32'h00000000};
        vecs[8]  = '{6'h1F, 32'h13579BDF, 32'hFFFFFFFF, 16'hFFFF, 4'b1010, 1'b0, 32'h00000000};
        vecs[9]  = '{6'h20, 32'h55555555, 32'h11112222, 16'h8000, 4'b0000, 1'b1, 32'h11112222};
        vecs[10] = '{6'h00, 32'h66666666, 32'h33334444, 16'h0001, 4'b0000, 1'b1, 32'h33334444};
        vecs[11] = '{6'h2C, 32'h77777777, 32'h55556666, 16'h8000, 4'b0000, 1'b1, 32'h55556666};

        rst_n      = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        in_opcode  = 6'h28;
        in_ra_data = 32'hFFFFFFFF;
        in_rb_data = 32'hFFFFFFFF;
        in_lit     = 16'hFFFF;

        // Reset held two cycles with in_valid high
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 80'(out_valid), 80'(0));
        chk("rst_op_count", 80'(op_count), 80'(0));
        chk("rst_outputs", 80'(outs()), 80'(0));
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 80'(in_ready), 80'(1));
        chk("rst_idle_valid", 80'(out_valid), 80'(0));

        // Table vectors, one at a time
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i]);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 80'(out_valid), 80'(1));
            chk($sformatf("vec%0d_data", i), 80'(outs()), 80'(vexp(vecs[i])));
            @(negedge clk);
            chk($sformatf("vec%0d_count", i), 80'(op_count), 80'(i + 1));
            chk($sformatf("vec%0d_drain", i), 80'(out_valid), 80'(0));
        end

        // Backpressure: three back-to-back inputs with out_ready low
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 3; i++) begin
            drive(vecs[i]);
            #1;
            if (in_valid && in_ready) acc++;
            @(negedge clk);
            if (i == 1) chk("bp_in_ready_low", 80'(in_ready), 80'(0));
            if (i >= 1) chk($sformatf("bp_stable%0d", i), 80'(outs()), 80'(vexp(vecs[0])));
        end
        chk("bp_accepted", 80'(acc), 80'(2));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_second_valid", 80'(out_valid), 80'(1));
        chk("bp_second_data", 80'(outs()), 80'(vexp(vecs[1])));
        @(negedge clk);
        chk("bp_drained", 80'(out_valid), 80'(0));
        chk("bp_count", 80'(op_count), 80'(14));

        // 100 streaming ops; narrow counter wraps to 100 mod 16
        do_reset();
        stream(100);
        chk("stream_count", 80'(op_count), 80'(100));
        chk("stream_count4", 80'(op_count4), 80'(4));

        // 17 transfers wrap the 4-bit counter to 1
        do_reset();
        stream(17);
        chk("wrap_count4", 80'(op_count4), 80'(1));
        chk("wrap_count16", 80'(op_count), 80'(17));

        // Fill to TWO, then reset with out_ready high
        out_ready = 1'b0;
        drive(vecs[4]);
        @(negedge clk);
        drive(vecs[5]);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mid_two_ready", 80'(in_ready), 80'(0));
        rst_n     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 80'(out_valid), 80'(0));
        chk("mid_rst_count", 80'(op_count4), 80'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after_valid", 80'(out_valid), 80'(0));
        chk("mid_after_ready", 80'(in_ready), 80'(1));
        @(negedge clk);
        chk("mid_after_count", 80'(op_count), 80'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
